rhythm_judge: RTL and testbench

//  Per-lane hit judge sitting directly downstream of the button push-control stage: consumes the
//  one-cycle press pulses i_fPush[3:0] and grades each against a note judgment window.

---
 rtl/rhythm_pkg.sv | 42 ++++
 rtl/rhythm_judge_lane.sv | 101 ++++++++++
 rtl/rhythm_judge.sv | 127 ++++++++++++
 tb/tb_rhythm_judge.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm hit judge.
// Grades, lane FSM states, window timing and point values.
package rhythm_pkg;

  localparam int LANES     = 4;
  localparam int LW        = $clog2(LANES);
  localparam int WIN_TICKS = 16;
  localparam int CEN       = WIN_TICKS / 2;
  localparam int PERFECT_W = 2;
  localparam int GOOD_W    = 5;
  localparam int CW        = $clog2(WIN_TICKS + 1);

  localparam logic [15:0] PTS_PERFECT = 16'd100;
  localparam logic [15:0] PTS_GOOD    = 16'd50;

  typedef enum logic [1:0] {
    G_NONE    = 2'd0,
    G_PERFECT = 2'd1,
    G_GOOD    = 2'd2,
    G_MISS    = 2'd3
  } grade_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_WINDOW = 1'b1
  } lane_st_e;

  function automatic grade_e grade_of(input logic [CW-1:0] c);
    logic [CW-1:0] off;
    grade_e        g;
    off = (c >= CW'(CEN)) ? (c - CW'(CEN))
                          : (CW'(CEN) - c);
    if (off <= CW'(PERFECT_W))
      g = G_PERFECT;
    else if (off <= CW'(GOOD_W))
      g = G_GOOD;
    else
      g = G_MISS;
    return g;
  endfunction

endpackage

// File: rtl/rhythm_judge_lane.sv
// One lane: window FSM, tick counter, grader and a single
// pending-result slot drained by the top-level arbiter.
module judge_lane
  import rhythm_pkg::*;
(
  input  logic   i_Clk,
  input  logic   i_Rst,
  input  logic   i_Tick,
  input  logic   i_Open,
  input  logic   i_Push,
  input  logic   i_Clr,
  output logic   o_Full,
  output grade_e o_Grade,
  output logic   o_Drop
);

  lane_st_e      r_State;
  lane_st_e      w_Next;
  logic [CW-1:0] r_Cnt;
  logic [CW-1:0] w_CntNext;
  grade_e        w_New;
  logic          w_Timeout;
  logic          w_Block;
  logic          r_Full;
  grade_e        r_Grade;

  assign w_Timeout = i_Tick
                   && (r_Cnt == CW'(WIN_TICKS - 1));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State <= S_IDLE;
      r_Cnt   <= '0;
    end else begin
      r_State <= w_Next;
      r_Cnt   <= w_CntNext;
    end
  end

  always_comb begin
    w_Next    = r_State;
    w_CntNext = r_Cnt;
    unique case (r_State)
      S_IDLE: begin
        if (i_Open) begin
          w_CntNext = '0;
          w_Next    = i_Push ? S_IDLE : S_WINDOW;
        end
      end
      S_WINDOW: begin
        if (i_Open) begin
          w_CntNext = '0;
        end else if (i_Push || w_Timeout) begin
          w_Next    = S_IDLE;
          w_CntNext = '0;
        end else if (i_Tick) begin
          w_CntNext = r_Cnt + 1'b1;
        end
      end
      default: w_Next = S_IDLE;
    endcase
  end

  // A push always grades the note that was already open.
  always_comb begin
    w_New = G_NONE;
    unique case (r_State)
      S_IDLE: begin
        if (i_Open && i_Push)
          w_New = grade_of('0);
      end
      S_WINDOW: begin
        if (i_Push)
          w_New = grade_of(r_Cnt);
        else if (i_Open || w_Timeout)
          w_New = G_MISS;
      end
      default: w_New = G_NONE;
    endcase
  end

  assign w_Block = r_Full && !i_Clr;
  assign o_Drop  = (w_New != G_NONE) && w_Block;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Full  <= 1'b0;
      r_Grade <= G_NONE;
    end else if ((w_New != G_NONE) && !w_Block) begin
      r_Full  <= 1'b1;
      r_Grade <= w_New;
    end else if (i_Clr) begin
      r_Full  <= 1'b0;
      r_Grade <= G_NONE;
    end
  end

  assign o_Full  = r_Full;
  assign o_Grade = r_Grade;

endmodule

// File: rtl/rhythm_judge.sv
// Rhythm hit judge top: per-lane graders, round-robin result
// arbiter, score/combo accumulators and sticky drop flag.
module rhythm_judge
  import rhythm_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Tick,
  input  logic [LANES-1:0] i_NoteOpen,
  input  logic [LANES-1:0] i_fPush,
  output logic             o_Judge_Valid,
  output logic [1:0]       o_Judge_Lane,
  output logic [1:0]       o_Judge_Result,
  output logic [15:0]      o_Score,
  output logic [7:0]       o_Combo,
  output logic [7:0]       o_MaxCombo,
  output logic             o_Drop
);

  logic [LANES-1:0] w_Full;
  logic [LANES-1:0] w_Clr;
  logic [LANES-1:0] w_DropEv;
  grade_e           w_Grade [LANES];

  logic [LW-1:0]    r_Ptr;
  logic [LW-1:0]    w_Idx;
  logic [LW-1:0]    w_GntLane;
  logic             w_Any;
  grade_e           w_GntGrade;

  logic             r_Valid;
  logic [1:0]       r_Lane;
  grade_e           r_Result;
  logic [15:0]      r_Score;
  logic [7:0]       r_Combo;
  logic [7:0]       r_MaxCombo;
  logic             r_Drop;

  logic [15:0]      w_Pts;
  logic [16:0]      w_Sum;
  logic [15:0]      w_ScoreSat;
  logic [7:0]       w_ComboInc;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    judge_lane u_lane (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Tick  (i_Tick),
      .i_Open  (i_NoteOpen[g]),
      .i_Push  (i_fPush[g]),
      .i_Clr   (w_Clr[g]),
      .o_Full  (w_Full[g]),
      .o_Grade (w_Grade[g]),
      .o_Drop  (w_DropEv[g])
    );
  end

  // First full slot at or after the pointer wins.
  always_comb begin
    w_Any     = 1'b0;
    w_GntLane = '0;
    w_Idx     = '0;
    for (int k = 0; k < LANES; k++) begin
      w_Idx = r_Ptr + LW'(k);
      if (!w_Any && w_Full[w_Idx]) begin
        w_Any     = 1'b1;
        w_GntLane = w_Idx;
      end
    end
  end

  always_comb begin
    w_Clr = '0;
    if (w_Any)
      w_Clr[w_GntLane] = 1'b1;
  end

  assign w_GntGrade = w_Grade[w_GntLane];

  assign w_Pts = (w_GntGrade == G_PERFECT)
               ? PTS_PERFECT : PTS_GOOD;
  assign w_Sum = {1'b0, r_Score} + {1'b0, w_Pts};
  assign w_ScoreSat = w_Sum[16] ? 16'hFFFF
                                : w_Sum[15:0];
  assign w_ComboInc = (r_Combo == 8'hFF) ? 8'hFF
                                         : r_Combo + 8'd1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Ptr      <= '0;
      r_Valid    <= 1'b0;
      r_Lane     <= '0;
      r_Result   <= G_NONE;
      r_Score    <= '0;
      r_Combo    <= '0;
      r_MaxCombo <= '0;
      r_Drop     <= 1'b0;
    end else begin
      r_Valid  <= w_Any;
      r_Lane   <= w_Any ? 2'(w_GntLane) : 2'd0;
      r_Result <= w_Any ? w_GntGrade : G_NONE;
      r_Drop   <= r_Drop | (|w_DropEv);
      if (w_Any) begin
        r_Ptr <= w_GntLane + 1'b1;
        unique case (w_GntGrade)
          G_PERFECT, G_GOOD: begin
            r_Score <= w_ScoreSat;
            r_Combo <= w_ComboInc;
            if (w_ComboInc > r_MaxCombo)
              r_MaxCombo <= w_ComboInc;
          end
          G_MISS:  r_Combo <= '0;
          default: ;
        endcase
      end
    end
  end

  assign o_Judge_Valid  = r_Valid;
  assign o_Judge_Lane   = r_Lane;
  assign o_Judge_Result = r_Result;
  assign o_Score        = r_Score;
  assign o_Combo        = r_Combo;
  assign o_MaxCombo     = r_MaxCombo;
  assign o_Drop         = r_Drop;

endmodule

// File: tb/tb_rhythm_judge.sv
// Bench for rhythm_judge: directed scenarios plus random
// traffic checked against a note-level reference model.
module tb_rhythm_judge;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Tick = 1'b0;
  logic [3:0] i_NoteOpen = '0;
  logic [3:0] i_fPush = '0;
  logic       o_Judge_Valid;
  logic [1:0] o_Judge_Lane;
  logic [1:0] o_Judge_Result;
  logic [15:0] o_Score;
  logic [7:0] o_Combo;
  logic [7:0] o_MaxCombo;
  logic       o_Drop;

  int n_chk = 0;
  int n_err = 0;

  rhythm_judge dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_Tick         (i_Tick),
    .i_NoteOpen     (i_NoteOpen),
    .i_fPush        (i_fPush),
    .o_Judge_Valid  (o_Judge_Valid),
    .o_Judge_Lane   (o_Judge_Lane),
    .o_Judge_Result (o_Judge_Result),
    .o_Score        (o_Score),
    .o_Combo        (o_Combo),
    .o_MaxCombo     (o_MaxCombo),
    .o_Drop         (o_Drop)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference model: note state per lane, pending results,
  // fair rotation of reporting and score bookkeeping.
  bit m_open [4];
  int m_ticks [4];
  int m_pend [4];
  int m_ptr, m_score, m_combo, m_max;
  bit m_drop;
  int e_valid, e_lane, e_res;

  function automatic int judge(input int t);
    int off;
    off = (t > 8) ? t - 8 : 8 - t;
    if (off <= 2) return 1;
    if (off <= 5) return 2;
    return 3;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < 4; l++) begin
      m_open[l] = 0; m_ticks[l] = 0; m_pend[l] = 0;
    end
    m_ptr = 0; m_score = 0; m_combo = 0; m_max = 0;
    m_drop = 0; e_valid = 0; e_lane = 0; e_res = 0;
  endtask

  task automatic cyc(input logic [3:0] op,
                     input logic [3:0] pu,
                     input logic tk);
    int g, l, res;
    i_NoteOpen = op; i_fPush = pu; i_Tick = tk;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      l = (m_ptr + k) % 4;
      if (g < 0 && m_pend[l] != 0) g = l;
    end
    if (g >= 0) begin
      e_valid = 1; e_lane = g; e_res = m_pend[g];
      m_pend[g] = 0;
      m_ptr = (g + 1) % 4;
      if (e_res == 3) m_combo = 0;
      else begin
        m_score += (e_res == 1) ? 100 : 50;
        if (m_score > 65535) m_score = 65535;
        if (m_combo < 255) m_combo++;
        if (m_combo > m_max) m_max = m_combo;
      end
    end else begin
      e_valid = 0; e_lane = 0; e_res = 0;
    end
    for (int q = 0; q < 4; q++) begin
      res = 0;
      if (m_open[q]) begin
        if (pu[q]) res = judge(m_ticks[q]);
        else if (op[q]) res = 3;
        else if (tk && m_ticks[q] == 15) res = 3;
        if (op[q]) m_ticks[q] = 0;
        else if (pu[q]) m_open[q] = 0;
        else if (tk) begin
          m_ticks[q]++;
          if (m_ticks[q] == 16) m_open[q] = 0;
        end
      end else if (op[q]) begin
        m_ticks[q] = 0;
        if (pu[q]) res = judge(0);
        else m_open[q] = 1;
      end
      if (res != 0) begin
        if (m_pend[q] != 0) m_drop = 1;
        else m_pend[q] = res;
      end
    end
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Rst = 1; i_NoteOpen = 0; i_fPush = 0; i_Tick = 0;
    @(posedge i_Clk);
    #1;
    i_Rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({o_Judge_Valid, o_Judge_Lane, o_Judge_Result,
         o_Score, o_Combo, o_MaxCombo, o_Drop} !== '0) begin
      n_err++;
      $display("FAIL reset: got v%0d l%0d r%0d s%0d c%0d m%0d d%0d want all 0",
        o_Judge_Valid, o_Judge_Lane, o_Judge_Result,
        o_Score, o_Combo, o_MaxCombo, o_Drop);
    end
  endtask

  task automatic test_perfect();
    do_reset();
    cyc(4'b0001, 0, 0);
    repeat (8) cyc(0, 0, 1);
    cyc(0, 4'b0001, 0);
    cyc(0, 0, 0);
    n_chk++;
    if (o_Judge_Valid !== 1 || o_Judge_Lane !== 0 ||
        o_Judge_Result !== 1 || o_Score !== 100 ||
        o_Combo !== 1) begin
      n_err++;
      $display("FAIL perfect: got v%0d l%0d r%0d s%0d c%0d want 1 0 1 100 1",
        o_Judge_Valid, o_Judge_Lane, o_Judge_Result,
        o_Score, o_Combo);
    end
    cyc(0, 0, 0);
    n_chk++;
    if (o_Judge_Valid !== 0 || o_Judge_Result !== 0) begin
      n_err++;
      $display("FAIL perfect_once: got v%0d r%0d want 0 0",
        o_Judge_Valid, o_Judge_Result);
    end
  endtask

  task automatic test_good_miss();
    do_reset();
    cyc(4'b0010, 0, 0);
    repeat (12) cyc(0, 0, 1);
    cyc(0, 4'b0010, 1);
    cyc(0, 0, 0);
    n_chk++;
    if (o_Judge_Valid !== 1 || o_Judge_Lane !== 1 ||
        o_Judge_Result !== 2 || o_Score !== 50 ||
        o_Combo !== 1) begin
      n_err++;
      $display("FAIL good: got v%0d l%0d r%0d s%0d c%0d want 1 1 2 50 1",
        o_Judge_Valid, o_Judge_Lane, o_Judge_Result,
        o_Score, o_Combo);
    end
    cyc(4'b0010, 0, 0);
    repeat (15) cyc(0, 0, 1);
    cyc(0, 4'b0010, 0);
    cyc(0, 0, 0);
    n_chk++;
    if (o_Judge_Valid !== 1 || o_Judge_Result !== 3 ||
        o_Score !== 50 || o_Combo !== 0 ||
        o_MaxCombo !== 1) begin
      n_err++;
      $display("FAIL late_miss: got v%0d r%0d s%0d c%0d m%0d want 1 3 50 0 1",
        o_Judge_Valid, o_Judge_Result, o_Score,
        o_Combo, o_MaxCombo);
    end
  endtask

  task automatic test_timeout();
    int seen;
    do_reset();
    cyc(4'b0100, 0, 0);
    repeat (16) cyc(0, 0, 1);
    n_chk++;
    if (o_Judge_Valid !== 0) begin
      n_err++;
      $display("FAIL timeout_early: got v%0d want 0",
        o_Judge_Valid);
    end
    cyc(0, 0, 0);
    n_chk++;
    if (o_Judge_Valid !== 1 || o_Judge_Lane !== 2 ||
        o_Judge_Result !== 3) begin
      n_err++;
      $display("FAIL timeout: got v%0d l%0d r%0d want 1 2 3",
        o_Judge_Valid, o_Judge_Lane, o_Judge_Result);
    end
    seen = 0;
    cyc(0, 4'b0100, 0);
    repeat (3) begin
      cyc(0, 0, 1);
      if (o_Judge_Valid) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL idle_push: got %0d strobes want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(4'b1111, 0, 0);
    repeat (8) cyc(0, 0, 1);
    cyc(0, 4'b1111, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0);
      n_chk++;
      if (o_Judge_Valid !== 1 || o_Judge_Lane !== k ||
          o_Judge_Result !== 1 || o_Combo !== k + 1) begin
        n_err++;
        $display("FAIL b2b[%0d]: got v%0d l%0d r%0d c%0d want 1 %0d 1 %0d",
          k, o_Judge_Valid, o_Judge_Lane, o_Judge_Result,
          o_Combo, k, k + 1);
      end
    end
    n_chk++;
    if (o_Score !== 400 || o_MaxCombo !== 4) begin
      n_err++;
      $display("FAIL b2b_score: got s%0d m%0d want 400 4",
        o_Score, o_MaxCombo);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 656; i++) begin
      cyc(4'b0001, 0, 0);
      repeat (8) cyc(0, 0, 1);
      cyc(0, 4'b0001, 0);
      cyc(0, 0, 0);
      if (i == 654) begin
        n_chk++;
        if (o_Score !== 16'd65500) begin
          n_err++;
          $display("FAIL preload: got %0d want 65500", o_Score);
        end
      end
    end
    n_chk++;
    if (o_Score !== 16'hFFFF || o_Combo !== 8'd255 ||
        o_MaxCombo !== 8'd255) begin
      n_err++;
      $display("FAIL saturate: got s%0d c%0d m%0d want 65535 255 255",
        o_Score, o_Combo, o_MaxCombo);
    end
  endtask

  task automatic test_drop();
    do_reset();
    cyc(4'b1111, 0, 1);
    cyc(4'b1000, 4'b0111, 1);
    n_chk++;
    if (o_Drop !== 0) begin
      n_err++;
      $display("FAIL drop_early: got %0d want 0", o_Drop);
    end
    cyc(4'b1000, 0, 1);
    cyc(0, 0, 1);
    n_chk++;
    if (o_Drop !== 1) begin
      n_err++;
      $display("FAIL drop: got %0d want 1", o_Drop);
    end
    repeat (5) cyc(0, 0, 1);
    n_chk++;
    if (o_Drop !== 1) begin
      n_err++;
      $display("FAIL drop_sticky: got %0d want 1", o_Drop);
    end
    do_reset();
    n_chk++;
    if ({o_Judge_Valid, o_Score, o_Combo,
         o_MaxCombo, o_Drop} !== '0) begin
      n_err++;
      $display("FAIL drop_reset: got v%0d s%0d c%0d d%0d want 0",
        o_Judge_Valid, o_Score, o_Combo, o_Drop);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    do_reset();
    cyc(4'b0011, 0, 0);
    repeat (4) cyc(0, 0, 1);
    cyc(0, 4'b0001, 0);
    do_reset();
    seen = 0;
    cyc(0, 4'b0010, 1);
    repeat (4) begin
      cyc(0, 0, 1);
      if (o_Judge_Valid) seen++;
    end
    n_chk++;
    if (seen !== 0 || o_Score !== 0) begin
      n_err++;
      $display("FAIL mid_reset: got %0d strobes s%0d want 0 0",
        seen, o_Score);
    end
  endtask

  task automatic test_random();
    logic [3:0] op, pu;
    logic tk;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      op = '0; pu = '0;
      for (int l = 0; l < 4; l++) begin
        op[l] = ($urandom_range(0, 24) == 0);
        pu[l] = ($urandom_range(0, 9) == 0);
      end
      tk = ($urandom_range(0, 1) == 1);
      cyc(op, pu, tk);
      n_chk++;
      if (o_Judge_Valid !== e_valid[0] ||
          o_Judge_Lane !== e_lane[1:0] ||
          o_Judge_Result !== e_res[1:0]) begin
        n_err++;
        $display("FAIL rnd_judge@%0d: got v%0d l%0d r%0d want v%0d l%0d r%0d",
          n, o_Judge_Valid, o_Judge_Lane, o_Judge_Result,
          e_valid, e_lane, e_res);
      end
      n_chk++;
      if (o_Score !== m_score[15:0] ||
          o_Combo !== m_combo[7:0] ||
          o_MaxCombo !== m_max[7:0]) begin
        n_err++;
        $display("FAIL rnd_score@%0d: got s%0d c%0d m%0d want s%0d c%0d m%0d",
          n, o_Score, o_Combo, o_MaxCombo,
          m_score, m_combo, m_max);
      end
      n_chk++;
      if (o_Drop !== m_drop) begin
        n_err++;
        $display("FAIL rnd_drop@%0d: got %0d want %0d",
          n, o_Drop, m_drop);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_perfect();
    test_good_miss();
    test_timeout();
    test_back_to_back();
    test_drop();
    test_mid_reset();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors",
      n_chk, n_err);
    $finish;
  end

endmodule
